// File: rtl/depp_pkg.sv
// Shared DEPP definitions: bus width, op-code constants used by both the
// host and responder blocks, the host state encoding, and op decode helpers.
package depp_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] DEPP_OP_AWR = 2'd0;
  localparam logic [1:0] DEPP_OP_ARD = 2'd1;
  localparam logic [1:0] DEPP_OP_DWR = 2'd2;
  localparam logic [1:0] DEPP_OP_DRD = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } depp_state_e;

  // Reads are the odd op codes; address ops are the low pair.
  function automatic logic op_is_read(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic op_is_addr(input logic [1:0] op);
    return ~op[1];
  endfunction

endpackage

// File: rtl/depp_host_if.sv
// Command/response channel between on-chip logic and the DEPP host.
//   cmd_valid/cmd_ready : single-beat command handshake
//   cmd_op, cmd_wdata   : op code and write byte
//   rsp_valid           : one-cycle completion pulse (no backpressure)
//   rsp_rdata, rsp_err  : read byte and timeout flag, valid with rsp_valid
// master: the command issuer.  slave: the depp_host block.
interface depp_host_if;
  import depp_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/depp_sync.sv
// N-stage synchronizer for a single asynchronous input.
//   clk, rst : clock and synchronous active-high reset (clears the chain)
//   d        : asynchronous input
//   q        : d delayed by SYNC_STAGES flops
module depp_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/depp_host.sv
// DEPP host (initiator): runs one address/data read or write cycle per
// accepted command and reports completion on the response channel.
//   clk, rst   : clock, synchronous active-high reset
//   cmd        : command/response channel (depp_host_if.slave)
//   depp_db    : bidirectional data bus, driven only for host writes
//   depp_astb  : address strobe, active low
//   depp_dstb  : data strobe, active low
//   depp_write : 0 = host writes, 1 = host reads
//   depp_wait  : responder handshake, asynchronous
module depp_host
  import depp_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  depp_host_if.slave        cmd,
  inout  wire  [DATA_W-1:0] depp_db,
  output logic              depp_astb,
  output logic              depp_dstb,
  output logic              depp_write,
  input  logic              depp_wait
);

  localparam logic [15:0] SETUP_LIM   = 16'(SETUP_CYC);
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  depp_state_e       state, state_next;
  logic [15:0]       cnt, cnt_next, cnt_inc;
  logic              err, err_next;
  logic [DATA_W-1:0] rdata_next;
  logic [1:0]        op_q, op_cur;
  logic [DATA_W-1:0] wdata_q;
  logic              db_oe;
  logic              wait_s;
  logic              accept;
  logic              is_read, is_addr;

  logic astb_d, dstb_d, write_d, oe_d, ready_d, valid_d;

  depp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wait_sync (
    .clk (clk),
    .rst (rst),
    .d   (depp_wait),
    .q   (wait_s)
  );

  assign accept  = cmd.cmd_valid && cmd.cmd_ready;
  // In IDLE the op register is not loaded yet, so decode the incoming op so
  // the first SETUP cycle already presents the right depp_write / enable.
  assign op_cur  = (state == IDLE) ? cmd.cmd_op : op_q;
  assign is_read = op_is_read(op_cur);
  assign is_addr = op_is_addr(op_cur);
  assign cnt_inc = sat_inc(cnt);

  assign depp_db = db_oe ? wdata_q : 'z;

  // Next-state, counter, error and read-capture logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    err_next   = err;
    rdata_next = cmd.rsp_rdata;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SETUP;
          cnt_next   = '0;
          err_next   = 1'b0;
        end
      end
      SETUP: begin
        cnt_next = cnt_inc;
        // Hold off the strobe while the responder still shows wait from
        // an earlier cycle; that time counts toward the timeout.
        if (cnt_inc >= SETUP_LIM && !wait_s) begin
          state_next = STROBE;
          cnt_next   = '0;
        end else if (cnt_inc >= TIMEOUT_LIM) begin
          state_next = RELEASE;
          cnt_next   = '0;
          err_next   = 1'b1;
          if (is_read) rdata_next = '0;
        end
      end
      STROBE: begin
        cnt_next = cnt_inc;
        if (wait_s) begin
          state_next = RELEASE;
          cnt_next   = '0;
          if (is_read) rdata_next = depp_db;
        end else if (cnt_inc >= TIMEOUT_LIM) begin
          state_next = RELEASE;
          cnt_next   = '0;
          err_next   = 1'b1;
          if (is_read) rdata_next = '0;
        end
      end
      RELEASE: begin
        cnt_next = cnt_inc;
        if (!wait_s) begin
          state_next = DONE;
        end else if (cnt_inc >= TIMEOUT_LIM) begin
          state_next = DONE;
          err_next   = 1'b1;
          if (is_read) rdata_next = '0;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state register after each edge.
  always_comb begin
    astb_d  = 1'b1;
    dstb_d  = 1'b1;
    write_d = 1'b1;
    oe_d    = 1'b0;
    ready_d = 1'b0;
    valid_d = 1'b0;
    case (state_next)
      IDLE:  ready_d = 1'b1;
      SETUP, RELEASE: begin
        write_d = is_read;
        oe_d    = ~is_read;
      end
      STROBE: begin
        write_d = is_read;
        oe_d    = ~is_read;
        astb_d  = ~is_addr;
        dstb_d  = is_addr;
      end
      DONE:    valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      err           <= 1'b0;
      depp_astb     <= 1'b1;
      depp_dstb     <= 1'b1;
      depp_write    <= 1'b1;
      db_oe         <= 1'b0;
      cmd.cmd_ready <= 1'b0;
      cmd.rsp_valid <= 1'b0;
      cmd.rsp_err   <= 1'b0;
      cmd.rsp_rdata <= '0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      err           <= err_next;
      depp_astb     <= astb_d;
      depp_dstb     <= dstb_d;
      depp_write    <= write_d;
      db_oe         <= oe_d;
      cmd.cmd_ready <= ready_d;
      cmd.rsp_valid <= valid_d;
      cmd.rsp_err   <= err_next;
      cmd.rsp_rdata <= rdata_next;
    end
  end

  // Command payload: loaded on accept, not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= cmd.cmd_op;
      wdata_q <= cmd.cmd_wdata;
    end
  end

endmodule

// File: tb/tb_depp_host.sv
// Bench for depp_host: a behavioural DEPP responder (address register plus
// 128 data registers; data reads with address bit 7 set return the inverse),
// directed commands with hand-computed expected responses pushed into a
// queue, and a response monitor that pops and compares on every rsp_valid.
module tb_depp_host;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  wire  [7:0] depp_db;
  logic       depp_astb, depp_dstb, depp_write;
  logic       depp_wait;

  depp_host_if cif();

  depp_host #(.SETUP_CYC(2), .TIMEOUT_CYC(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cif),
    .depp_db    (depp_db),
    .depp_astb  (depp_astb),
    .depp_dstb  (depp_dstb),
    .depp_write (depp_write),
    .depp_wait  (depp_wait)
  );

  always #5 clk = ~clk;

  // Responder model
  logic       resp_mute = 1'b0;
  logic       resp_wait = 1'b0;
  logic       resp_oe   = 1'b0;
  logic [7:0] resp_out  = 8'h00;
  logic [7:0] resp_addr = 8'h00;
  logic [7:0] regs [128];

  assign depp_wait = resp_wait;
  assign depp_db   = resp_oe ? resp_out : 8'hzz;

  always @(posedge clk) begin
    if (depp_astb && depp_dstb) begin
      resp_wait <= 1'b0;
      resp_oe   <= 1'b0;
    end else if (!resp_mute && !resp_wait) begin
      if (!depp_astb) begin
        if (depp_write) begin
          resp_out <= resp_addr;
          resp_oe  <= 1'b1;
        end else begin
          resp_addr <= depp_db;
        end
      end else begin
        if (depp_write) begin
          resp_out <= resp_addr[7] ? ~regs[resp_addr[6:0]] : regs[resp_addr[6:0]];
          resp_oe  <= 1'b1;
        end else begin
          regs[resp_addr[6:0]] <= depp_db;
        end
      end
      resp_wait <= 1'b1;
    end
  end

  // Scoreboard
  typedef struct {
    logic [7:0] rd;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   rsp_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (cif.rsp_valid) begin
      rsp_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=rsp_valid required=none rdata=0x%0h", cif.rsp_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_err", {31'd0, cif.rsp_err}, {31'd0, e.err});
        check("rsp_rdata", {24'd0, cif.rsp_rdata}, {24'd0, e.rd});
      end
    end
  end

  task automatic wait_ready(input string name);
    int t = 0;
    @(negedge clk);
    while (!cif.cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({name, "_ready_wait"}, {31'd0, cif.cmd_ready}, 32'd1);
  endtask

  // Issue one command, push its expected response, and gather strobe
  // statistics until the completion pulse (bounded).
  task automatic do_cmd(input string name, input logic [1:0] op, input logic [7:0] wd,
                        input logic [7:0] exp_rd, input logic exp_err,
                        output int n_astb, output int n_dstb, output int bad_write);
    exp_t e;
    int   t;
    wait_ready(name);
    cif.cmd_op    = op;
    cif.cmd_wdata = wd;
    cif.cmd_valid = 1'b1;
    e.rd  = exp_rd;
    e.err = exp_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1 cif.cmd_valid = 1'b0;
    n_astb = 0; n_dstb = 0; bad_write = 0; t = 0;
    do begin
      @(negedge clk);
      if (!depp_astb) n_astb++;
      if (!depp_dstb) n_dstb++;
      if ((!depp_astb || !depp_dstb) && depp_write !== op[0]) bad_write++;
      t++;
    end while (!cif.rsp_valid && t < 2000);
    check({name, "_rsp_seen"}, {31'd0, cif.rsp_valid}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int na, nd, bw, acc, base, t;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'd0;
    cif.cmd_wdata = 8'h00;
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_astb", {31'd0, depp_astb}, 32'd1);
    check("rst_dstb", {31'd0, depp_dstb}, 32'd1);
    check("rst_write", {31'd0, depp_write}, 32'd1);
    check("rst_ready", {31'd0, cif.cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, cif.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", {24'd0, cif.rsp_rdata}, 32'd0);
    check("rst_rsp_err", {31'd0, cif.rsp_err}, 32'd0);
    rst = 1'b0;

    // Address write 0x05
    do_cmd("awr", 2'd0, 8'h05, 8'h00, 1'b0, na, nd, bw);
    check("awr_astb_low", {31'd0, (na != 0)}, 32'd1);
    check("awr_dstb_idle", na == 0 ? 32'hFFFF : nd, 32'd0);
    check("awr_write_level", bw, 32'd0);
    check("awr_resp_addr", {24'd0, resp_addr}, 32'h05);

    // Address read back
    do_cmd("ard", 2'd1, 8'hEE, 8'h05, 1'b0, na, nd, bw);
    check("ard_astb_low", {31'd0, (na != 0)}, 32'd1);
    check("ard_write_level", bw, 32'd0);

    // Data round trip through the inverting alias
    do_cmd("dwr", 2'd2, 8'h3C, 8'h05, 1'b0, na, nd, bw);
    check("dwr_dstb_low", {31'd0, (nd != 0)}, 32'd1);
    check("dwr_astb_idle", na, 32'd0);
    check("dwr_write_level", bw, 32'd0);
    check("dwr_resp_reg", {24'd0, regs[5]}, 32'h3C);
    do_cmd("awr85", 2'd0, 8'h85, 8'h05, 1'b0, na, nd, bw);
    do_cmd("drd", 2'd3, 8'h00, 8'hC3, 1'b0, na, nd, bw);
    check("drd_write_level", bw, 32'd0);

    // Timeout: responder never answers
    resp_mute = 1'b1;
    do_cmd("tmo", 2'd3, 8'h00, 8'h00, 1'b1, na, nd, bw);
    check("tmo_strobe_len", nd, 32'd16);
    @(negedge clk);
    check("tmo_ready_after", {31'd0, cif.cmd_ready}, 32'd1);
    resp_mute = 1'b0;

    // Busy: valid held high; accepts only when idle, one response each
    cif.cmd_op    = 2'd1;
    cif.cmd_wdata = 8'h00;
    cif.cmd_valid = 1'b1;
    acc  = 0;
    base = rsp_count;
    for (int i = 0; i < 80; i++) begin
      if (cif.cmd_ready) begin
        exp_t e;
        check("busy_no_outstanding", exp_q.size(), 32'd0);
        e.rd  = 8'h85;
        e.err = 1'b0;
        exp_q.push_back(e);
        acc++;
      end
      @(negedge clk);
    end
    cif.cmd_valid = 1'b0;
    t = 0;
    while ((exp_q.size() != 0 || !cif.cmd_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("busy_drained", exp_q.size(), 32'd0);
    check("busy_rsp_per_accept", rsp_count - base, acc);
    check("busy_multi_accept", {31'd0, (acc >= 3)}, 32'd1);

    // Reset in the middle of a data write strobe
    resp_mute = 1'b1;
    wait_ready("rstmid");
    cif.cmd_op    = 2'd2;
    cif.cmd_wdata = 8'h5A;
    cif.cmd_valid = 1'b1;
    @(posedge clk);
    #1 cif.cmd_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (depp_dstb && t < 50);
    check("rstmid_dstb_low", {31'd0, depp_dstb}, 32'd0);
    check("rstmid_db_driven", {24'd0, depp_db}, 32'h5A);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_astb", {31'd0, depp_astb}, 32'd1);
    check("rstmid_dstb", {31'd0, depp_dstb}, 32'd1);
    check("rstmid_write", {31'd0, depp_write}, 32'd1);
    check("rstmid_db_released", {31'd0, (depp_db !== 8'h5A)}, 32'd1);
    check("rstmid_ready", {31'd0, cif.cmd_ready}, 32'd0);
    check("rstmid_rsp_valid", {31'd0, cif.rsp_valid}, 32'd0);
    check("rstmid_rsp_rdata", {24'd0, cif.rsp_rdata}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    resp_mute = 1'b0;
    base = rsp_count;
    repeat (6) @(negedge clk);
    check("rstmid_no_rsp", rsp_count - base, 32'd0);

    do_cmd("ard2", 2'd1, 8'h00, 8'h85, 1'b0, na, nd, bw);
    check("ard2_write_level", bw, 32'd0);

    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
